// File: rtl/snake_pkg.sv
// Shared grid geometry, cell encodings and direction helpers for the snake game logic.
package snake_pkg;
  localparam int GRID_W = 80;
  localparam int GRID_H = 60;

  localparam logic [2:0] CELL_EMPTY = 3'b000;
  localparam logic [2:0] CELL_SNAKE = 3'b100;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
  } cell_t;

  // Opposite directions differ only in bit 1.
  function automatic logic [1:0] rev_dir(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction
endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of body cells, head pushed at the write pointer, tail read at the read pointer.
module snake_body_fifo import snake_pkg::*; #(
  parameter int DEPTH   = 64,
  parameter int START_X = 40,
  parameter int START_Y = 30
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  push,
  input  cell_t push_data,
  input  logic  pop,
  output cell_t tail
);
  localparam int AW = $clog2(DEPTH);

  cell_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // After reset the buffer holds exactly the start cell.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem[0] <= cell_t'{x: 7'(START_X), y: 6'(START_Y)};
      wr_ptr <= AW'(1);
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign tail = mem[rd_ptr];
endmodule

// File: rtl/snake_mover.sv
// Per-tick snake step: probe next cell, paint new head, erase vacated tail; flags food and collisions.
module snake_mover import snake_pkg::*; #(
  parameter int MAX_LEN = 64,
  parameter int GROW    = 3,
  parameter int START_X = 40,
  parameter int START_Y = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [1:0] dir,
  input  logic [6:0] food_x,
  input  logic [5:0] food_y,
  output logic [6:0] rd_x,
  output logic [5:0] rd_y,
  input  logic [2:0] rd_value,
  output logic       wr_req,
  input  logic       wr_grant,
  output logic [6:0] wr_x,
  output logic [5:0] wr_y,
  output logic [2:0] wr_value,
  output logic [6:0] head_x,
  output logic [5:0] head_y,
  output logic [6:0] length,
  output logic       ate,
  output logic       dead
);
  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_WR_HEAD = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_CALC    = 3'd3;
  localparam logic [2:0] S_PROBE   = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_ERASE   = 3'd6;
  localparam logic [2:0] S_DEAD    = 3'd7;

  localparam cell_t START = cell_t'{x: 7'(START_X), y: 6'(START_Y)};

  logic [2:0] state;
  logic [1:0] cur_dir;
  cell_t      head, probe, nxt, tail, erase_cell, wr_cell;
  logic [6:0] grow_cnt;
  logic [7:0] grow_sum;
  logic       init_paint;
  logic       wall, push, pop;

  always_comb begin
    nxt = head;
    case (cur_dir)
      DIR_RIGHT: nxt.x = head.x + 7'd1;
      DIR_DOWN:  nxt.y = head.y + 6'd1;
      DIR_LEFT:  nxt.x = head.x - 7'd1;
      default:   nxt.y = head.y - 6'd1;
    endcase
  end

  assign wall = (nxt.x == 7'd0) || (nxt.x == 7'(GRID_W - 1)) ||
                (nxt.y == 6'd0) || (nxt.y == 6'(GRID_H - 1));
  assign grow_sum = {1'b0, grow_cnt} + 8'(GROW);
  assign push     = (state == S_CHECK) && (rd_value == CELL_EMPTY);
  assign pop      = (state == S_ERASE) && wr_grant;

  snake_body_fifo #(.DEPTH(MAX_LEN), .START_X(START_X), .START_Y(START_Y)) u_body (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (probe),
    .pop       (pop),
    .tail      (tail)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_INIT;
      cur_dir    <= DIR_RIGHT;
      head       <= START;
      probe      <= START;
      erase_cell <= START;
      grow_cnt   <= '0;
      length     <= 7'd1;
      ate        <= 1'b0;
      init_paint <= 1'b1;
    end else begin
      ate <= 1'b0;
      case (state)
        S_INIT: state <= S_WR_HEAD;
        S_IDLE: if (tick) begin
          if (dir != rev_dir(cur_dir)) cur_dir <= dir;
          state <= S_CALC;
        end
        S_CALC: if (wall) state <= S_DEAD;
                else begin
                  probe <= nxt;
                  state <= S_PROBE;
                end
        S_PROBE: state <= S_CHECK;
        // Tail is captured before the push: at full length the push reuses its slot.
        S_CHECK: if (rd_value != CELL_EMPTY) state <= S_DEAD;
                 else begin
                   head       <= probe;
                   erase_cell <= tail;
                   if (probe == cell_t'{x: food_x, y: food_y}) begin
                     ate      <= 1'b1;
                     grow_cnt <= grow_sum[7] ? 7'h7f : grow_sum[6:0];
                   end
                   state <= S_WR_HEAD;
                 end
        S_WR_HEAD: if (wr_grant) begin
          if (init_paint) begin
            init_paint <= 1'b0;
            state      <= S_IDLE;
          end else if (grow_cnt != '0 && length < 7'(MAX_LEN)) begin
            length   <= length + 7'd1;
            grow_cnt <= grow_cnt - 7'd1;
            state    <= S_IDLE;
          end else begin
            grow_cnt <= '0;
            state    <= S_ERASE;
          end
        end
        S_ERASE: if (wr_grant) state <= S_IDLE;
        default: ;
      endcase
    end
  end

  assign wr_req   = (state == S_WR_HEAD) || (state == S_ERASE);
  assign wr_cell  = (state == S_ERASE) ? erase_cell : head;
  assign wr_x     = wr_cell.x;
  assign wr_y     = wr_cell.y;
  assign wr_value = (state == S_ERASE) ? CELL_EMPTY : CELL_SNAKE;
  assign rd_x     = probe.x;
  assign rd_y     = probe.y;
  assign head_x   = head.x;
  assign head_y   = head.y;
  assign dead     = (state == S_DEAD);
endmodule
